// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame constants, parity sense.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int BIT_CYCLES_DEF = 434;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic PARITY_EVEN = 1'b1;
  localparam logic PARITY_ODD  = 1'b0;

  // XOR over data plus parity bit that a correct frame produces for the selected sense.
  function automatic logic parity_target(input logic even_odd);
    return (even_odd == PARITY_ODD) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-flop synchronizer, falling-edge detect and bit decision.
// With UART_RX_MAJORITY_EN the bit decision is a 2-of-3 vote over three consecutive synchronized samples.
module uart_rx_sampler (
  input  logic sys_clk,
  input  logic rst,
  input  logic serial_in,
  output logic fall_edge,
  output logic rx_bit
);

  logic rxs_meta;
  logic rxs;
  logic rxs_d;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rxs_meta <= 1'b1;
      rxs      <= 1'b1;
      rxs_d    <= 1'b1;
    end else begin
      rxs_meta <= serial_in;
      rxs      <= rxs_meta;
      rxs_d    <= rxs;
    end
  end

  assign fall_edge = rxs_d & ~rxs;

`ifdef UART_RX_MAJORITY_EN
  logic rxs_dd;

  always_ff @(posedge sys_clk) begin
    if (rst) rxs_dd <= 1'b1;
    else     rxs_dd <= rxs_d;
  end

  // Decision taken one cycle after the nominal sample point, voting over sample-1, sample, sample+1.
  assign rx_bit = (rxs & rxs_d) | (rxs & rxs_dd) | (rxs_d & rxs_dd);
`else
  assign rx_bit = rxs;
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: start, DATA_BITS data (LSB first), parity, stop, timed by an internal bit timer on sys_clk.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling (all decisions one cycle later).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 even_odd,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(BIT_CYCLES);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_LAG = 1;
`else
  localparam int SAMPLE_LAG = 0;
`endif

  // Only the start decision needs the lag; later decisions are timed from it and inherit the shift.
  localparam logic [TW-1:0] TC_HALF  = TW'(BIT_CYCLES / 2 - 1 + SAMPLE_LAG);
  localparam logic [TW-1:0] TC_BIT   = TW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic fall_edge;
  logic rx_bit;

  uart_rx_sampler u_sampler (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .serial_in (serial_in),
    .fall_edge (fall_edge),
    .rx_bit    (rx_bit)
  );

  rx_state_e            state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (rx_enable && fall_edge) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == TC_HALF) begin
            timer <= '0;
            if (rx_bit) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == TC_BIT) begin
            timer     <= '0;
            shift_reg <= {rx_bit, shift_reg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state <= PARITY;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PARITY: begin
          if (timer == TC_BIT) begin
            timer      <= '0;
            parity_bit <= rx_bit;
            state      <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == TC_BIT) begin
            timer      <= '0;
            rx_data    <= shift_reg;
            rx_valid   <= 1'b1;
            parity_err <= (^shift_reg ^ parity_bit) != parity_target(even_odd);
            frame_err  <= ~rx_bit;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized frames against a queue-based frame model for uart_receiver (BIT_CYCLES=16).
module tb_uart_receiver;

  localparam int BC = 16;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       rx_enable;
  logic       even_odd;
  logic       serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  uart_receiver #(.BIT_CYCLES(BC), .DATA_BITS(8)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .rx_enable  (rx_enable),
    .even_odd   (even_odd),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_mem [0:255];
  int   obs_cnt     = 0;
  int   busy_cycles = 0;
  int   rd_ptr      = 0;

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      if (obs_cnt < 256) obs_mem[obs_cnt] = '{data: rx_data, perr: parity_err, ferr: frame_err};
      obs_cnt++;
    end
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Model: a frame's parity is wrong when the count of ones in data+parity has the wrong oddness.
  function automatic logic model_perr(input logic [7:0] d, input logic par, input logic eo);
    int ones;
    ones = $countones(d) + int'(par);
    return eo ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  function automatic logic good_parity(input logic [7:0] d, input logic eo);
    logic odd_ones;
    odd_ones = ($countones(d) % 2) == 1;
    return eo ? odd_ones : ~odd_ones;
  endfunction

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (BC) @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit drop_en = 1'b0);
    drive_bit(1'b0);
    if (drop_en) rx_enable = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_q.push_back('{data: d, perr: model_perr(d, par, even_odd), ferr: ~stop});
  endtask

  task automatic compare_all(input string tag);
    int n_obs;
    rec_t e;
    rec_t o;
    n_obs = obs_cnt - rd_ptr;
    check({tag, "_count"}, n_obs, exp_q.size());
    while (exp_q.size() > 0 && rd_ptr < obs_cnt) begin
      e = exp_q.pop_front();
      o = obs_mem[rd_ptr];
      rd_ptr++;
      check({tag, "_data"}, o.data, e.data);
      check({tag, "_perr"}, o.perr, e.perr);
      check({tag, "_ferr"}, o.ferr, e.ferr);
    end
    exp_q.delete();
    rd_ptr = obs_cnt;
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_parity_err"}, parity_err, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int snap;
    logic [7:0] d;
    logic par;
    logic stop;

    rst       = 1'b1;
    rx_enable = 1'b1;
    even_odd  = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_outputs_clear("reset");
    rst = 1'b0;
    idle_bits(2);

    // Clean even-parity frame and busy duration.
    snap = busy_cycles;
    even_odd = 1'b1;
    send_frame(8'hCC, 1'b0, 1'b1);
    expect_frame(8'hCC, 1'b0, 1'b1);
    idle_bits(2);
    compare_all("cc_even");
    check("busy_len", ((busy_cycles - snap) >= 10 * BC) && ((busy_cycles - snap) <= 11 * BC), 1);

    // Odd parity expected: 0xCC/p0 is wrong, 0x01/p0 is right.
    even_odd = 1'b0;
    send_frame(8'hCC, 1'b0, 1'b1);
    expect_frame(8'hCC, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1);
    expect_frame(8'h01, 1'b0, 1'b1);
    idle_bits(2);
    compare_all("odd_par");

    // Framing error followed by a 40-bit break: exactly one frame.
    even_odd = 1'b1;
    send_frame(8'h55, good_parity(8'h55, 1'b1), 1'b0);
    expect_frame(8'h55, good_parity(8'h55, 1'b1), 1'b0);
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    compare_all("break");
    check("break_busy", busy, 0);
    idle_bits(2);
    compare_all("break_release");
    send_frame(8'h5A, good_parity(8'h5A, 1'b1), 1'b1);
    expect_frame(8'h5A, good_parity(8'h5A, 1'b1), 1'b1);
    idle_bits(1);
    compare_all("after_break");

    // Short glitch: START entered and rejected.
    snap = busy_cycles;
    serial_in = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    serial_in = 1'b1;
    idle_bits(3);
    check("glitch_busy_seen", busy_cycles > snap, 1);
    check("glitch_busy_end", busy, 0);
    compare_all("glitch");

    // Reset in the middle of data bit 3 of 0xA5.
    d = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    serial_in = d[3];
    repeat (BC / 2) @(posedge sys_clk);
    #1;
    rst       = 1'b1;
    serial_in = 1'b1;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    check_outputs_clear("mid_rst");
    idle_bits(12);
    compare_all("mid_rst_none");
    send_frame(8'h3C, good_parity(8'h3C, 1'b1), 1'b1);
    expect_frame(8'h3C, good_parity(8'h3C, 1'b1), 1'b1);
    idle_bits(1);
    compare_all("after_rst");

    // Back-to-back frames with no idle gap.
    send_frame(8'h12, good_parity(8'h12, 1'b1), 1'b1);
    expect_frame(8'h12, good_parity(8'h12, 1'b1), 1'b1);
    send_frame(8'h34, good_parity(8'h34, 1'b1), 1'b1);
    expect_frame(8'h34, good_parity(8'h34, 1'b1), 1'b1);
    idle_bits(1);
    compare_all("b2b");

    // rx_enable dropped mid-frame completes the frame, then blocks the next one.
    send_frame(8'h9E, good_parity(8'h9E, 1'b1), 1'b1, 1'b1);
    expect_frame(8'h9E, good_parity(8'h9E, 1'b1), 1'b1);
    idle_bits(1);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle_bits(1);
    compare_all("rx_enable");
    rx_enable = 1'b1;
    idle_bits(1);

    // Randomized frames, parity sense, parity correctness and stop bit.
    for (int n = 0; n < 12; n++) begin
      d        = 8'($urandom_range(0, 255));
      even_odd = 1'($urandom_range(0, 1));
      par      = good_parity(d, even_odd);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop     = ($urandom_range(0, 4) != 0);
      send_frame(d, par, stop);
      expect_frame(d, par, stop);
      if (!stop) idle_bits(1);
      else       idle_bits($urandom_range(0, 2));
    end
    idle_bits(1);
    compare_all("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
